bsg_gateway_clock_slowdown_bank: RTL and testbench
==================================================

BSG_GATEWAY_CLOCK_SLOWDOWN_BANK -- requirements
Module: bsg_gateway_clock_slowdown_bank

Interface
REQ-001 SHALL have parameter num_clk_p, default 5: number of generated clock channels (>=1).
REQ-002 SHALL have parameter width_p, default 10: width of every per-channel counter and divide value.
REQ-003 SHALL have port clk_i  input  1  single source clock; every register is clocked on its rising edge.
REQ-004 SHALL have port reset_i  input  1  asynchronous active-high reset.
REQ-005 SHALL have port fast_val_i  input  num_clk_p*width_p  per-channel half-period-minus-1 for normal mode; channel c occupies bits [c*width_p +: width_p].
REQ-006 SHALL have port slow_val_i  input  num_clk_p*width_p  per-channel half-period-minus-1 for slow mode; same packing as fast_val_i.
REQ-007 SHALL have port slow_en_i  input  1  global mode request: 1 = slow (tag programming), 0 = normal.
REQ-008 SHALL have port run_i  input  num_clk_p  per-channel run enable: 1 = toggle, 0 = park output low.
REQ-009 SHALL have port clk_r_o  output  num_clk_p  registered downsampled clocks.
REQ-010 SHALL have port mode_r_o  output  num_clk_p  mode currently applied per channel (1 = slow).
REQ-011 SHALL have port synced_o  output  1  level: every mode_r_o bit equals slow_en_i.
REQ-012 SHALL have port sync_pulse_o  output  1  one-cycle pulse on each rising edge of synced_o.

Function
REQ-013 SHALL hold, per channel, counter ctr_r (width_p bits), applied divide value val_r (width_p bits), clk_r, mode_r.
REQ-014 SHALL define a toggle point for a channel as any cycle where ctr_r == val_r.
REQ-015 At a toggle point: ctr_r <= 0; val_r <= slow_en_i ? slow_val : fast_val for that channel; mode_r <= slow_en_i.
REQ-016 At a toggle point: clk_r SHALL invert if run_i=1; if run_i=0, clk_r SHALL go to 0 when it was 1 and stay 0 when it was 0.
REQ-017 In a non-toggle cycle: ctr_r <= ctr_r+1; val_r, mode_r and clk_r unchanged.
REQ-018 Each phase SHALL last exactly val_r+1 cycles; output frequency SHALL be f(clk_i)/(2*(val_r+1)); val 0 gives f/2.
REQ-019 Value, mode and run changes SHALL take effect only at toggle points, so clk_r_o never carries a phase shorter than min(old,new)+1 cycles: no glitches and no runt pulses.
REQ-020 ctr_r SHALL never exceed val_r and never wrap; val = 2^width_p-1 yields 2^width_p-cycle phases.
REQ-021 Channels SHALL be fully independent; toggle points of different channels need not align.
REQ-022 synced_o SHALL be combinational from mode_r and slow_en_i; sync_pulse_o SHALL be synced_o AND NOT synced_q, where synced_q is synced_o registered.
REQ-023 A slow_en_i change coinciding with a toggle point SHALL be applied in that same toggle; a change in any other cycle SHALL be applied at the channel's next toggle point.
REQ-024 fast_val_i/slow_val_i changes between toggle points SHALL have no effect until sampled.

Reset
REQ-025 While reset_i=1, asynchronously and with no clk_i edge required: ctr_r=0, val_r=0, clk_r_o=0, mode_r_o=0, synced_q=0.
REQ-026 Consequently, in the first post-reset cycle every channel is at a toggle point: it rises if run_i=1 and samples its value and mode.
REQ-027 Reset asserted mid-phase SHALL force clk_r_o low immediately; a truncated high phase is permitted only in this case.

Verification
REQ-028 num_clk_p=2, width_p=4, fast_val=0, slow_en_i=0, run_i=11 -> both clk_r_o toggle every cycle (period 2); synced_o=1 throughout.
REQ-029 ch0 fast=1, slow=7; raise slow_en_i in 1st cycle of a high phase -> high lasts 2 cycles, then 8-cycle phases; mode_r_o[0] rises at that toggle; sync_pulse_o fires once, when the last channel switches.
REQ-030 ch1 fast=3; drop run_i[1] mid-high -> high completes its 4 cycles, then clk_r_o[1] stays 0; re-raise run_i[1] -> rises exactly at the next toggle point.
REQ-031 Assert reset_i between clk_i edges while clk_r_o=11 -> clk_r_o=00 and mode_r_o=00 immediately; release -> both rise on the first edge.
REQ-032 fast_val=15 -> phases of exactly 16 cycles, ctr_r never >15; change fast_val mid-phase to 2 -> current phase still 16, next phase 3.
REQ-033 slow_en_i toggle and run_i drop in the same toggle-point cycle -> new val/mode latched, clk_r_o goes/stays low, no extra edge.

Source files
------------

// File: rtl/bsg_gateway_clock_slowdown_bank.sv
// Bank of independent glitch-free clock dividers with a global
// fast/slow mode switch applied per channel at its toggle points.
module bsg_gateway_clock_slowdown_bank #(
  parameter int num_clk_p = 5,
  parameter int width_p   = 10
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic [num_clk_p*width_p-1:0] fast_val_i,
  input  logic [num_clk_p*width_p-1:0] slow_val_i,
  input  logic                         slow_en_i,
  input  logic [num_clk_p-1:0]         run_i,
  output logic [num_clk_p-1:0]         clk_r_o,
  output logic [num_clk_p-1:0]         mode_r_o,
  output logic                         synced_o,
  output logic                         sync_pulse_o
);

  logic r_synced_q;

  for (genvar c = 0; c < num_clk_p; c++) begin : g_ch
    logic [width_p-1:0] r_ctr;
    logic [width_p-1:0] r_val;
    logic               r_clk;
    logic               r_mode;
    logic               w_tog;
    logic [width_p-1:0] w_fast;
    logic [width_p-1:0] w_slow;

    assign w_tog  = (r_ctr == r_val);
    assign w_fast = fast_val_i[c*width_p +: width_p];
    assign w_slow = slow_val_i[c*width_p +: width_p];

    // Count out a phase; at its end resample value/mode and move the clock
    always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
        r_ctr  <= '0;
        r_val  <= '0;
        r_clk  <= 1'b0;
        r_mode <= 1'b0;
      end else if (w_tog) begin
        r_ctr  <= '0;
        r_val  <= slow_en_i ? w_slow : w_fast;
        r_mode <= slow_en_i;
        r_clk  <= run_i[c] & ~r_clk;
      end else begin
        r_ctr  <= r_ctr + width_p'(1);
      end
    end

    assign clk_r_o[c]  = r_clk;
    assign mode_r_o[c] = r_mode;
  end

  assign synced_o = (mode_r_o == {num_clk_p{slow_en_i}});

  // Delayed copy of synced_o for rising-edge detection
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) r_synced_q <= 1'b0;
    else         r_synced_q <= synced_o;
  end

  assign sync_pulse_o = synced_o & ~r_synced_q;

endmodule

// File: tb/tb_bsg_gateway_clock_slowdown_bank.sv
// Directed bench for the clock slowdown bank, two 4-bit channels.
// Inputs change and outputs are checked on the falling edge.
module tb_bsg_gateway_clock_slowdown_bank;

  logic       clk_i = 1'b0;
  logic       reset_i;
  logic [7:0] fast_val_i;
  logic [7:0] slow_val_i;
  logic       slow_en_i;
  logic [1:0] run_i;
  logic [1:0] clk_r_o;
  logic [1:0] mode_r_o;
  logic       synced_o;
  logic       sync_pulse_o;

  int n_checks = 0;
  int n_errors = 0;

  bsg_gateway_clock_slowdown_bank #(
    .num_clk_p(2),
    .width_p  (4)
  ) dut (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .fast_val_i  (fast_val_i),
    .slow_val_i  (slow_val_i),
    .slow_en_i   (slow_en_i),
    .run_i       (run_i),
    .clk_r_o     (clk_r_o),
    .mode_r_o    (mode_r_o),
    .synced_o    (synced_o),
    .sync_pulse_o(sync_pulse_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    tick();
    tick();
    reset_i = 1'b0;
  endtask

  int pulses;

  initial begin
    // fast divide 0: both channels toggle every cycle
    reset_i    = 1'b1;
    fast_val_i = 8'h00;
    slow_val_i = 8'h00;
    slow_en_i  = 1'b0;
    run_i      = 2'b11;
    @(negedge clk_i);
    check("rst_clk", int'(clk_r_o), 0);
    check("rst_mode", int'(mode_r_o), 0);
    check("rst_synced", int'(synced_o), 1);
    reset_i = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      check("f2_clk", int'(clk_r_o), (k % 2 == 1) ? 3 : 0);
      check("f2_synced", int'(synced_o), 1);
    end

    // slow mode request in first cycle of a high phase
    fast_val_i = 8'h31;
    slow_val_i = 8'h77;
    do_reset();
    tick();
    check("sl_p1_clk", int'(clk_r_o), 3);
    slow_en_i = 1'b1;
    #1;
    check("sl_unsynced", int'(synced_o), 0);
    pulses = 0;
    for (int k = 2; k <= 18; k++) begin
      tick();
      if (sync_pulse_o) pulses++;
      check("sl_clk0", int'(clk_r_o[0]), int'(k <= 2 || k >= 11));
      check("sl_clk1", int'(clk_r_o[1]), int'(k <= 4 || k >= 13));
      if (k == 3) check("sl_mode_p3", int'(mode_r_o), 1);
      if (k == 5) begin
        check("sl_mode_p5", int'(mode_r_o), 3);
        check("sl_pulse_p5", int'(sync_pulse_o), 1);
      end
    end
    check("sl_pulses", pulses, 1);

    // run drop mid-high on ch1, then re-raise while parked
    slow_en_i  = 1'b0;
    fast_val_i = 8'h30;
    slow_val_i = 8'h00;
    run_i      = 2'b11;
    do_reset();
    for (int k = 1; k <= 17; k++) begin
      tick();
      check("run_clk1", int'(clk_r_o[1]),
            int'(k <= 4 || (k >= 13 && k <= 16)));
      if (k == 2)  run_i = 2'b01;
      if (k == 10) run_i = 2'b11;
    end

    // asynchronous reset between edges
    fast_val_i = 8'h33;
    slow_val_i = 8'h33;
    slow_en_i  = 1'b1;
    do_reset();
    tick();
    check("ar_pre_clk", int'(clk_r_o), 3);
    check("ar_pre_mode", int'(mode_r_o), 3);
    #2 reset_i = 1'b1;
    #1;
    check("ar_clk", int'(clk_r_o), 0);
    check("ar_mode", int'(mode_r_o), 0);
    @(negedge clk_i);
    reset_i = 1'b0;
    tick();
    check("ar_rel_clk", int'(clk_r_o), 3);

    // max divide, value change mid-phase
    slow_en_i  = 1'b0;
    fast_val_i = 8'hFF;
    slow_val_i = 8'h00;
    run_i      = 2'b01;
    do_reset();
    for (int k = 1; k <= 21; k++) begin
      tick();
      check("mx_clk", int'(clk_r_o),
            int'(k <= 16 || k >= 20));
      if (k == 5) fast_val_i = 8'h22;
    end

    // mode change and run drop on the same toggle point
    fast_val_i = 8'h11;
    slow_val_i = 8'h22;
    slow_en_i  = 1'b0;
    run_i      = 2'b11;
    do_reset();
    tick();
    tick();
    check("co_p2_clk0", int'(clk_r_o[0]), 1);
    slow_en_i = 1'b1;
    run_i     = 2'b10;
    tick();
    check("co_p3_clk0", int'(clk_r_o[0]), 0);
    check("co_p3_mode0", int'(mode_r_o[0]), 1);
    for (int k = 4; k <= 9; k++) begin
      tick();
      check("co_clk0", int'(clk_r_o[0]), 0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
